// File: rtl/vector_out_pkg.sv
// rtl/vector_out_pkg.sv - shared sizes, lane/vector types and FSM states for the vector output serializer
package vector_out_pkg;

   localparam int VECTOR_SIZE  = 6;
   localparam int OUTPUT_WIDTH = 8;
   localparam int FIFO_DEPTH   = 8;

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);
   localparam int IDX_W   = $clog2(VECTOR_SIZE);

   typedef logic [OUTPUT_WIDTH-1:0] lane_t;
   typedef lane_t [VECTOR_SIZE-1:0] vec_t;

   typedef enum logic {
      IDLE,
      SEND
   } ser_state_e;

   localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(VECTOR_SIZE - 1);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/vector_output_serializer_if.sv
// rtl/vector_output_serializer_if.sv - CPU result input, byte stream output and status of the serializer
interface vector_output_serializer_if;
   import vector_out_pkg::*;

   logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] in_data;
   logic                                in_valid;
   lane_t                               byte_data;
   logic                                byte_valid;
   logic                                byte_ready;
   logic                                byte_last;
   logic [LEVEL_W-1:0]                  fifo_level;
   logic                                overflow;
   logic [15:0]                         drop_count;

   modport master (
      output in_data, in_valid, byte_ready,
      input  byte_data, byte_valid, byte_last, fifo_level, overflow, drop_count
   );

   modport slave (
      input  in_data, in_valid, byte_ready,
      output byte_data, byte_valid, byte_last, fifo_level, overflow, drop_count
   );

endinterface

// File: rtl/vector_out_fifo.sv
// rtl/vector_out_fifo.sv - whole-vector FIFO with show-ahead read and separate level counter
module vector_out_fifo
   import vector_out_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  vec_t               wr_data,
   output vec_t               rd_data,
   output logic               full,
   output logic               empty,
   output logic [LEVEL_W-1:0] level
);

   vec_t             mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage needs no reset; only pointers and level define what is valid.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) begin
            level <= level + 1'b1;
         end else if (pop && !push) begin
            level <= level - 1'b1;
         end
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (level == LEVEL_W'(FIFO_DEPTH));
   assign empty   = (level == '0);

endmodule

// File: rtl/vector_output_serializer.sv
// rtl/vector_output_serializer.sv - buffers CPU result vectors and streams them out one lane byte at a time
// Optional drop counter enabled by OUTSER_DROP_COUNT_EN.
module vector_output_serializer
   import vector_out_pkg::*;
(
   input  logic                      clock,
   input  logic                      reset,
   vector_output_serializer_if.slave bus
);

   ser_state_e       state;
   ser_state_e       state_n;
   logic [IDX_W-1:0] lane_idx;
   logic [IDX_W-1:0] lane_idx_n;
   vec_t             cur_vec;
   vec_t             cur_vec_n;
   vec_t             in_vec;
   vec_t             rd_data;
   logic             pop;
   logic             push;
   logic             drop;
   logic             full;
   logic             empty;
   logic             overflow_q;

   assign in_vec = bus.in_data;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push = bus.in_valid && (!full || pop);
   assign drop = bus.in_valid && full && !pop;

   vector_out_fifo u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .wr_data (in_vec),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .level   (bus.fifo_level)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         lane_idx <= '0;
         cur_vec  <= '0;
      end else begin
         state    <= state_n;
         lane_idx <= lane_idx_n;
         cur_vec  <= cur_vec_n;
      end
   end

   always_comb begin
      state_n    = state;
      lane_idx_n = lane_idx;
      cur_vec_n  = cur_vec;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               cur_vec_n  = rd_data;
               lane_idx_n = '0;
               state_n    = SEND;
            end
         end
         SEND: begin
            if (bus.byte_ready) begin
               if (lane_idx != LAST_LANE) begin
                  lane_idx_n = lane_idx + 1'b1;
               end else if (!empty) begin
                  // Back-to-back vectors: reload without an idle cycle.
                  pop        = 1'b1;
                  cur_vec_n  = rd_data;
                  lane_idx_n = '0;
               end else begin
                  lane_idx_n = '0;
                  state_n    = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.byte_valid = (state == SEND);
   assign bus.byte_data  = (state == SEND) ? cur_vec[lane_idx] : '0;
   assign bus.byte_last  = (state == SEND) && (lane_idx == LAST_LANE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end
   end

   assign bus.overflow = overflow_q;

`ifdef OUTSER_DROP_COUNT_EN
   logic [15:0] drop_cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         drop_cnt_q <= '0;
      end else if (drop) begin
         drop_cnt_q <= sat_inc16(drop_cnt_q);
      end
   end

   assign bus.drop_count = drop_cnt_q;
`else
   assign bus.drop_count = '0;
`endif

endmodule

// File: tb/tb_vector_output_serializer.sv
// tb/tb_vector_output_serializer.sv - table, directed and randomized checks of vector_output_serializer
module tb_vector_output_serializer;
   import vector_out_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   vector_output_serializer_if bus();

   vector_output_serializer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   // reference model: queue of stored vectors plus the vector being sent
   logic [47:0] fq[$];
   logic [47:0] m_cur;
   int          m_lane;
   bit          m_act;
   bit          m_ovf;
   int          m_drops;
   logic [7:0]  got[$];

   typedef struct {
      logic        v;
      logic [47:0] d;
      logic        r;
      logic        ebv;
      logic [7:0]  ebd;
      logic        elast;
      int          elvl;
   } row_t;
   row_t tbl[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [47:0] mkvec(input int base);
      logic [47:0] v;
      v = '0;
      for (int k = 0; k < VECTOR_SIZE; k++) v[k*8 +: 8] = 8'(base + k);
      return v;
   endfunction

   task automatic model_reset();
      fq.delete();
      m_cur   = '0;
      m_lane  = 0;
      m_act   = 0;
      m_ovf   = 0;
      m_drops = 0;
   endtask

   task automatic model_step(input logic v, input logic [47:0] d, input logic r);
      bit mpop, mfull;
      int n;
      n     = fq.size();
      mfull = (n == FIFO_DEPTH);
      mpop  = (n > 0) && (!m_act || (r && m_lane == VECTOR_SIZE - 1));
      if (m_act && r) begin
         if (m_lane < VECTOR_SIZE - 1) m_lane++;
         else m_act = 0;
      end
      if (mpop) begin
         m_cur  = fq.pop_front();
         m_lane = 0;
         m_act  = 1;
      end
      if (v) begin
         if (!mfull || mpop) begin
            fq.push_back(d);
         end else begin
            m_ovf = 1;
`ifdef OUTSER_DROP_COUNT_EN
            if (m_drops < 65535) m_drops++;
`endif
         end
      end
   endtask

   task automatic compare_all();
      logic [7:0] ebd;
      ebd = m_act ? m_cur[m_lane*8 +: 8] : 8'h00;
      chk("byte_valid", 64'(bus.byte_valid), 64'(m_act));
      chk("byte_data", 64'(bus.byte_data), 64'(ebd));
      chk("byte_last", 64'(bus.byte_last), 64'(m_act && m_lane == VECTOR_SIZE - 1));
      chk("fifo_level", 64'(bus.fifo_level), 64'(fq.size()));
      chk("overflow", 64'(bus.overflow), 64'(m_ovf));
      chk("drop_count", 64'(bus.drop_count), 64'(m_drops));
   endtask

   task automatic step(input logic v, input logic [47:0] d, input logic r);
      bus.in_valid   = v;
      bus.in_data    = d;
      bus.byte_ready = r;
      if (bus.byte_valid && r) got.push_back(bus.byte_data);
      @(posedge clock);
      model_step(v, d, r);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.byte_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(posedge clock);
      #1 reset = 1'b0;
      got.delete();
   endtask

   initial begin
      int peak, nbv, first_bv, last_bv;
      logic [7:0] pd;
      logic pv, pl;

      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.byte_ready = 1'b0;
      model_reset();
      @(posedge clock);
      #1;
      compare_all();
      reset = 1'b0;

      // single vector, ready held high
      tbl[0] = '{1'b1, 48'h060504030201, 1'b1, 1'b0, 8'h00, 1'b0, 1};
      for (int k = 1; k <= 6; k++) tbl[k] = '{1'b0, 48'h0, 1'b1, 1'b1, 8'(k), (k == 6), 0};
      tbl[7] = '{1'b0, 48'h0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].r);
         chk("tbl_valid", 64'(bus.byte_valid), 64'(tbl[i].ebv));
         chk("tbl_data", 64'(bus.byte_data), 64'(tbl[i].ebd));
         chk("tbl_last", 64'(bus.byte_last), 64'(tbl[i].elast));
         chk("tbl_level", 64'(bus.fifo_level), 64'(tbl[i].elvl));
      end

      // backpressure: ready 1,0,0,1,0,0,...
      do_reset();
      pv = 0; pd = 0; pl = 0;
      for (int i = 0; i < 24; i++) begin
         logic r;
         r = (i % 3 == 0);
         step(i == 0, mkvec(8'h11), r);
         if (pv && !bus.byte_ready) begin
            chk("bp_hold_valid", 64'(bus.byte_valid), 64'(1));
            chk("bp_hold_data", 64'(bus.byte_data), 64'(pd));
            chk("bp_hold_last", 64'(bus.byte_last), 64'(pl));
         end
         pv = bus.byte_valid; pd = bus.byte_data; pl = bus.byte_last;
      end
      chk("bp_count", 64'(got.size()), 64'(6));
      for (int j = 0; j < got.size(); j++) chk("bp_byte", 64'(got[j]), 64'(8'h11 + j));

      // burst of three vectors with no bubble
      do_reset();
      peak = 0; nbv = 0; first_bv = -1; last_bv = -1;
      for (int i = 0; i < 25; i++) begin
         step(i < 3, mkvec(8'h20 + 8 * i), 1'b1);
         if (int'(bus.fifo_level) > peak) peak = int'(bus.fifo_level);
         if (bus.byte_valid) begin
            nbv++;
            if (first_bv < 0) first_bv = i;
            last_bv = i;
         end
      end
      chk("burst_peak", 64'(peak), 64'(2));
      chk("burst_valid_cycles", 64'(nbv), 64'(18));
      chk("burst_no_bubble", 64'(last_bv - first_bv + 1), 64'(18));
      chk("burst_level_end", 64'(bus.fifo_level), 64'(0));
      chk("burst_count", 64'(got.size()), 64'(18));
      for (int j = 0; j < got.size(); j++) chk("burst_byte", 64'(got[j]), 64'(8'h20 + 8 * (j / 6) + j % 6));

      // overflow: ten vectors with the sink stalled
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b1, mkvec(16 * i + 1), 1'b0);
      chk("ovf_flag", 64'(bus.overflow), 64'(1));
      chk("ovf_level", 64'(bus.fifo_level), 64'(8));
`ifdef OUTSER_DROP_COUNT_EN
      chk("ovf_drop_count", 64'(bus.drop_count), 64'(1));
`else
      chk("ovf_drop_count", 64'(bus.drop_count), 64'(0));
`endif
      for (int i = 0; i < 60; i++) step(1'b0, 48'h0, 1'b1);
      chk("ovf_drain_count", 64'(got.size()), 64'(54));
      for (int j = 0; j < got.size(); j++) chk("ovf_drain_byte", 64'(got[j]), 64'(16 * (j / 6) + 1 + j % 6));
      chk("ovf_sticky", 64'(bus.overflow), 64'(1));

      // full FIFO, last-lane handshake and push in the same cycle
      do_reset();
      for (int i = 0; i < 9; i++) step(1'b1, mkvec(8 * i), 1'b0);
      chk("full_level", 64'(bus.fifo_level), 64'(8));
      chk("full_no_ovf", 64'(bus.overflow), 64'(0));
      for (int i = 0; i < 5; i++) step(1'b0, 48'h0, 1'b1);
      chk("full_at_last", 64'(bus.byte_last), 64'(1));
      step(1'b1, mkvec(8'hA0), 1'b1);
      chk("fullpop_no_ovf", 64'(bus.overflow), 64'(0));
      chk("fullpop_level", 64'(bus.fifo_level), 64'(8));
      chk("fullpop_next_lane0", 64'(bus.byte_data), 64'(8'd8));

      // reset after lane 2 of a vector has been sent
      do_reset();
      step(1'b1, mkvec(8'h40), 1'b1);
      step(1'b1, mkvec(8'h50), 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 48'h0, 1'b1);
      chk("mid_lane3", 64'(bus.byte_data), 64'(8'h43));
      do_reset();
      chk("rst_valid", 64'(bus.byte_valid), 64'(0));
      chk("rst_level", 64'(bus.fifo_level), 64'(0));
      step(1'b1, mkvec(8'h70), 1'b1);
      step(1'b0, 48'h0, 1'b1);
      chk("rst_restart_valid", 64'(bus.byte_valid), 64'(1));
      chk("rst_restart_lane0", 64'(bus.byte_data), 64'(8'h70));

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic v, r;
         v = ($urandom_range(0, 99) < 45);
         r = ((i / 200) % 2 == 1) ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 30);
         step(v, 48'({$urandom(), $urandom()}), r);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
